// File: rtl/coef_rom_sched.sv
// Round-robin read sequencer for the coefficient ROM: two requesters post (base, len)
// bursts, one is granted at a time, and the coefficients stream out on valid/ready.
module coef_rom_sched #(
    parameter int WIDTH_A = 12,
    parameter int DEPTH   = 80,
    parameter int DW      = 16,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH_A-1:0] base0,
    input  logic [LEN_W-1:0]   len0,
    output logic               ack0,
    input  logic               req1,
    input  logic [WIDTH_A-1:0] base1,
    input  logic [LEN_W-1:0]   len1,
    output logic               ack1,
    output logic [WIDTH_A-1:0] rom_addr,
    input  logic [DW-1:0]      rom_coef,
    output logic [DW-1:0]      out_coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               out_src,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [WIDTH_A-1:0] DEPTH_A = WIDTH_A'(DEPTH);
    localparam logic [WIDTH_A-1:0] LAST_A  = WIDTH_A'(DEPTH - 1);
    localparam logic [LEN_W-1:0]   ONE_L   = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_reg;
    logic [WIDTH_A-1:0] addr_reg;
    logic [WIDTH_A-1:0] addr_next;
    logic [LEN_W-1:0]   rem_reg;
    logic               src_reg;
    logic               rr_ptr_reg;
    logic [DW-1:0]      out_coef_reg;
    logic               out_valid_reg;
    logic               out_last_reg;
    logic               out_src_reg;
    logic               done_reg;
    logic               err_reg;

    logic [1:0]         req_vec;
    logic [WIDTH_A-1:0] base_vec [2];
    logic [LEN_W-1:0]   len_vec [2];
    logic [1:0]         bad_base;
    logic [1:0]         zero_len;
    logic [1:0]         ack_vec;
    logic               grant_any;
    logic               grant_id;
    logic               fetch;

    assign req_vec     = {req1, req0};
    assign base_vec[0] = base0;
    assign base_vec[1] = base1;
    assign len_vec[0]  = len0;
    assign len_vec[1]  = len1;

    // Requests are only looked at while idle; a tie goes to rr_ptr.
    assign grant_any = !rst && (state_reg == IDLE) && (req_vec != 2'b00);
    assign grant_id  = (req_vec == 2'b11) ? rr_ptr_reg : req_vec[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign bad_base[gi] = (base_vec[gi] >= DEPTH_A);
            assign zero_len[gi] = (len_vec[gi] == '0);
            assign ack_vec[gi]  = grant_any && (grant_id == 1'(gi));
        end
    endgenerate

    assign ack0 = ack_vec[0];
    assign ack1 = ack_vec[1];

    // A new ROM read is issued whenever the output register is free or being drained.
    assign fetch     = (state_reg == RUN) && (rem_reg != '0) && (!out_valid_reg || out_ready);
    assign addr_next = (addr_reg == LAST_A) ? '0 : addr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            rem_reg       <= '0;
            src_reg       <= 1'b0;
            rr_ptr_reg    <= 1'b0;
            out_coef_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        addr_reg   <= base_vec[grant_id];
                        rem_reg    <= len_vec[grant_id];
                        src_reg    <= grant_id;
                        rr_ptr_reg <= ~grant_id;
                        if (bad_base[grant_id] || zero_len[grant_id]) begin
                            done_reg <= 1'b1;
                            err_reg  <= bad_base[grant_id];
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fetch) begin
                        out_coef_reg  <= rom_coef;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (rem_reg == ONE_L);
                        out_src_reg   <= src_reg;
                        addr_reg      <= addr_next;
                        rem_reg       <= rem_reg - ONE_L;
                        if (rem_reg == ONE_L) begin
                            state_reg <= DRAIN;
                        end
                    end else if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (out_last_reg) begin
                            out_last_reg <= 1'b0;
                            state_reg    <= IDLE;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rom_addr  = addr_reg;
    assign out_coef  = out_coef_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_coef_rom_sched.sv
// Bench for coef_rom_sched: a ROM model feeds rom_coef, expected beats go into a
// scoreboard queue when a burst is requested and are popped as beats are accepted.
module tb_coef_rom_sched;

    localparam int WIDTH_A = 12;
    localparam int DEPTH   = 80;
    localparam int DW      = 16;
    localparam int LEN_W   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0 = 1'b0;
    logic [WIDTH_A-1:0] base0 = '0;
    logic [LEN_W-1:0]   len0 = '0;
    logic               ack0;
    logic               req1 = 1'b0;
    logic [WIDTH_A-1:0] base1 = '0;
    logic [LEN_W-1:0]   len1 = '0;
    logic               ack1;
    logic [WIDTH_A-1:0] rom_addr;
    logic [DW-1:0]      rom_coef;
    logic [DW-1:0]      out_coef;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_last;
    logic               out_src;
    logic               busy;
    logic               done;
    logic               err;

    typedef struct packed {
        logic [DW-1:0] coef;
        logic          last;
        logic          src;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    coef_rom_sched #(
        .WIDTH_A(WIDTH_A), .DEPTH(DEPTH), .DW(DW), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .base0(base0), .len0(len0), .ack0(ack0),
        .req1(req1), .base1(base1), .len1(len1), .ack1(ack1),
        .rom_addr(rom_addr), .rom_coef(rom_coef),
        .out_coef(out_coef), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_src(out_src),
        .busy(busy), .done(done), .err(err)
    );

    function automatic logic [DW-1:0] rom_model(input logic [WIDTH_A-1:0] a);
        case (a)
            12'd0:   rom_model = 16'h001e;
            12'd1:   rom_model = 16'h001f;
            12'd2:   rom_model = 16'h0024;
            12'd3:   rom_model = 16'h0022;
            12'd8:   rom_model = 16'h0027;
            12'd9:   rom_model = 16'h0022;
            12'd10:  rom_model = 16'h001c;
            12'd78:  rom_model = 16'h001d;
            12'd79:  rom_model = 16'h001b;
            default: rom_model = (a < 12'd80) ? (16'h0100 + {4'h0, a}) : 16'hdead;
        endcase
    endfunction

    assign rom_coef = rom_model(rom_addr);

    // Scoreboard: every accepted beat must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            $display("beat src=%0d coef=%04h last=%0d", out_src, out_coef, out_last);
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL beat_unexpected: got coef=%04h last=%0d src=%0d, required no beat",
                         out_coef, out_last, out_src);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({out_coef, out_last, out_src} !== mon_exp) begin
                    $display("FAIL beat: got coef=%04h last=%0d src=%0d, required coef=%04h last=%0d src=%0d",
                             out_coef, out_last, out_src, mon_exp.coef, mon_exp.last, mon_exp.src);
                end else begin
                    passes++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit which, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((which ? ack1 : ack0) === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_src, busy, done, err, ack0, ack1} !== 8'b0)
            $display("FAIL reset_flags: got %b, required 00000000",
                     {out_valid, out_last, out_src, busy, done, err, ack0, ack1});
        else passes++;
        checks++;
        if (rom_addr !== '0) $display("FAIL reset_addr: got %0d, required 0", rom_addr);
        else passes++;
        checks++;
        if (out_coef !== '0) $display("FAIL reset_coef: got %04h, required 0000", out_coef);
        else passes++;
    endtask

    task automatic test_single();
        bit got;
        tick();
        base0 = 12'd0; len0 = 8'd4; req0 = 1'b1; out_ready = 1'b1;
        exp_q.push_back('{16'h001e, 1'b0, 1'b0});
        exp_q.push_back('{16'h001f, 1'b0, 1'b0});
        exp_q.push_back('{16'h0024, 1'b0, 1'b0});
        exp_q.push_back('{16'h0022, 1'b1, 1'b0});
        wait_ack(1'b0, got);
        checks++;
        if (got !== 1'b1) $display("FAIL single_ack0: got no ack0, required ack0");
        else passes++;
        checks++;
        if (ack1 !== 1'b0) $display("FAIL single_ack1: got %b, required 0", ack1);
        else passes++;
        tick();
        req0 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_last, done} !== {(k >= 2 && k <= 5), (k == 5), (k == 6)})
                $display("FAIL single_timing T+%0d: got valid/last/done=%b, required %b", k,
                         {out_valid, out_last, done}, {(k >= 2 && k <= 5), (k == 5), (k == 6)});
            else passes++;
        end
        checks++;
        if (exp_q.size() !== 0) $display("FAIL single_drain: got %0d beats left, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_wrap();
        bit got;
        int wrap_addr[4] = '{78, 79, 0, 1};
        tick();
        base1 = 12'd78; len1 = 8'd4; req1 = 1'b1;
        exp_q.push_back('{16'h001d, 1'b0, 1'b1});
        exp_q.push_back('{16'h001b, 1'b0, 1'b1});
        exp_q.push_back('{16'h001e, 1'b0, 1'b1});
        exp_q.push_back('{16'h001f, 1'b1, 1'b1});
        wait_ack(1'b1, got);
        checks++;
        if (got !== 1'b1) $display("FAIL wrap_ack1: got no ack1, required ack1");
        else passes++;
        tick();
        req1 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                checks++;
                if (rom_addr !== WIDTH_A'(wrap_addr[k-1]))
                    $display("FAIL wrap_addr T+%0d: got %0d, required %0d", k, rom_addr, wrap_addr[k-1]);
                else passes++;
            end
            if (k == 6) begin
                checks++;
                if (done !== 1'b1) $display("FAIL wrap_done: got %b, required 1", done);
                else passes++;
            end
        end
        checks++;
        if (exp_q.size() !== 0) $display("FAIL wrap_drain: got %0d beats left, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_backpressure();
        bit got;
        tick();
        out_ready = 1'b0;
        base0 = 12'd8; len0 = 8'd3; req0 = 1'b1;
        exp_q.push_back('{16'h0027, 1'b0, 1'b0});
        exp_q.push_back('{16'h0022, 1'b0, 1'b0});
        exp_q.push_back('{16'h001c, 1'b1, 1'b0});
        wait_ack(1'b0, got);
        checks++;
        if (got !== 1'b1) $display("FAIL bp_ack0: got no ack0, required ack0");
        else passes++;
        tick();
        req0 = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) $display("FAIL bp_valid_t1: got %b, required 0", out_valid);
        else passes++;
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, out_coef, out_last} !== {1'b1, 16'h0027, 1'b0})
                $display("FAIL bp_hold T+%0d: got valid=%b coef=%04h last=%b, required valid=1 coef=0027 last=0",
                         k, out_valid, out_coef, out_last);
            else passes++;
        end
        tick();
        out_ready = 1'b1;
        wait_done(got);
        checks++;
        if (got !== 1'b1) $display("FAIL bp_done: got no done, required done");
        else passes++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL bp_drain: got %0d beats left, required 0", exp_q.size());
        else passes++;
    endtask

    task automatic test_simultaneous();
        bit got;
        rst = 1'b1;
        tick();
        base0 = 12'd0; len0 = 8'd2; base1 = 12'd78; len1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
                tick();
                req0 = 1'b1; req1 = 1'b1;
            end
            exp_q.push_back('{16'h001e, 1'b0, 1'b0});
            exp_q.push_back('{16'h001f, 1'b1, 1'b0});
            exp_q.push_back('{16'h001d, 1'b0, 1'b1});
            exp_q.push_back('{16'h001b, 1'b1, 1'b1});
            wait_ack(1'b0, got);
            checks++;
            if ({got, ack1} !== 2'b10)
                $display("FAIL simul_first_grant round %0d: got ack0_seen=%b ack1=%b, required 1 0", r, got, ack1);
            else passes++;
            tick();
            req0 = 1'b0;
            wait_ack(1'b1, got);
            checks++;
            if ({got, done} !== 2'b11)
                $display("FAIL simul_second_grant round %0d: got ack1_seen=%b done=%b, required 1 1", r, got, done);
            else passes++;
            tick();
            req1 = 1'b0;
            wait_done(got);
            checks++;
            if (got !== 1'b1) $display("FAIL simul_done round %0d: got no done, required done", r);
            else passes++;
            checks++;
            if (exp_q.size() !== 0)
                $display("FAIL simul_drain round %0d: got %0d beats left, required 0", r, exp_q.size());
            else passes++;
        end
    endtask

    task automatic test_degenerate();
        bit got;
        logic [WIDTH_A-1:0] bases[3] = '{12'd80, 12'd3, 12'd100};
        logic [LEN_W-1:0]   lens[3]  = '{8'd5, 8'd0, 8'd0};
        logic               errs[3]  = '{1'b1, 1'b0, 1'b1};
        for (int d = 0; d < 3; d++) begin
            tick();
            base0 = bases[d]; len0 = lens[d]; req0 = 1'b1;
            wait_ack(1'b0, got);
            checks++;
            if (got !== 1'b1) $display("FAIL degen_ack0 case %0d: got no ack0, required ack0", d);
            else passes++;
            tick();
            req0 = 1'b0;
            @(negedge clk);
            checks++;
            if ({done, err, busy, out_valid} !== {1'b1, errs[d], 1'b0, 1'b0})
                $display("FAIL degen_t1 case %0d: got done/err/busy/valid=%b, required %b", d,
                         {done, err, busy, out_valid}, {1'b1, errs[d], 1'b0, 1'b0});
            else passes++;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if ({out_valid, done, err} !== 3'b000)
                    $display("FAIL degen_quiet case %0d: got valid/done/err=%b, required 000", d,
                             {out_valid, done, err});
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        tick();
        out_ready = 1'b1;
        base0 = 12'd10; len0 = 8'd10; req0 = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{rom_model(WIDTH_A'((10 + i) % DEPTH)), 1'b0, 1'b0});
        wait_ack(1'b0, got);
        checks++;
        if (got !== 1'b1) $display("FAIL rmid_ack0: got no ack0, required ack0");
        else passes++;
        tick();
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, out_last, out_src, busy, done, err, ack0, ack1} !== 8'b0)
            $display("FAIL rmid_flags: got %b, required 00000000",
                     {out_valid, out_last, out_src, busy, done, err, ack0, ack1});
        else passes++;
        checks++;
        if ({rom_addr, out_coef} !== '0)
            $display("FAIL rmid_data: got addr=%0d coef=%04h, required 0 0000", rom_addr, out_coef);
        else passes++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL rmid_beats: got %0d beats left, required 0", exp_q.size());
        else passes++;
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) $display("FAIL rmid_nodone: got done/busy=%b, required 00", {done, busy});
        else passes++;
        tick();
        base1 = 12'd5; len1 = 8'd3; req1 = 1'b1;
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{rom_model(WIDTH_A'(5 + i)), (i == 2), 1'b1});
        wait_ack(1'b1, got);
        checks++;
        if (got !== 1'b1) $display("FAIL rmid_fresh_ack1: got no ack1, required ack1");
        else passes++;
        tick();
        req1 = 1'b0;
        wait_done(got);
        checks++;
        if (got !== 1'b1) $display("FAIL rmid_fresh_done: got no done, required done");
        else passes++;
        checks++;
        if (exp_q.size() !== 0) $display("FAIL rmid_fresh_drain: got %0d beats left, required 0", exp_q.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_simultaneous();
        test_degenerate();
        test_reset_mid();
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/coef_rom_sched.md
Name: coef_rom_sched

Overview:
- Arbitrating read sequencer for the 80-entry × 16-bit coefficient ROM.
- The ROM is combinational: address in, coefficient out.
- Two requesters (e.g. FFT butterfly stage, BWN scaling stage) each post a burst descriptor (base, length).
- The block grants one requester at a time (round-robin), walks the ROM addresses with wrap-around, and streams coefficients out on a valid/ready interface tagged with the source ID.

Parameters:
- WIDTH_A, 12, ROM address width.
- DEPTH, 80, number of valid ROM entries; addresses wrap DEPTH-1 -> 0.
- DW, 16, coefficient width.
- LEN_W, 8, burst length field width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req0  in  1  requester 0 burst request; held until ack0.
- base0  in  WIDTH_A  requester 0 start address.
- len0  in  LEN_W  requester 0 beat count.
- ack0  out  1  one-cycle pulse: requester 0 descriptor accepted.
- req1, base1, len1, ack1: same as the requester 0 ports, for requester 1.
- rom_addr  out  WIDTH_A  address to coefficient ROM.
- rom_coef  in  DW  ROM data, combinational from rom_addr.
- out_coef  out  DW  streamed coefficient.
- out_valid  out  1  out_coef valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the burst.
- out_src  out  1  ID of the granted requester.
- busy  out  1  burst in progress (state != IDLE).
- done  out  1  one-cycle pulse after the last beat is consumed.
- err  out  1  one-cycle pulse: the accepted descriptor had base >= DEPTH.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): every output is 0, state=IDLE, rr_ptr=0 (requester 0 favoured).
  - rst mid-burst discards remaining beats and the held output beat; no done or err is pulsed.
- States:
  - IDLE: no burst; waiting for a request.
  - RUN: issuing ROM reads.
  - DRAIN: all reads issued; waiting for the last beat to be consumed.
- IDLE arbitration (cycle T):
  - Only req0: grant 0.
  - Only req1: grant 1.
  - Both: grant the requester selected by rr_ptr.
  - In cycle T, ack for the grantee is pulsed. At the T edge: addr_q<=base, rem<=len, src<=grantee, rr_ptr<=~grantee.
  - Requests are ignored outside IDLE; no ack is given while busy.
- Descriptor checks at grant:
  - base >= DEPTH: ack plus err pulse in T+1, done pulse in T+1, zero beats, state stays IDLE.
  - len == 0: ack, done pulse in T+1, zero beats, state stays IDLE.
  - If both conditions hold, err and done still pulse together in T+1.
  - Otherwise: state=RUN from T+1.
- Address path: rom_addr = addr_q (registered). addr_q holds its value when no fetch occurs.
- RUN, each cycle where fetch = (rem != 0) && (!out_valid || out_ready):
  - out_coef<=rom_coef, out_valid<=1, out_last<=(rem==1), out_src<=src.
  - addr_q<=(addr_q==DEPTH-1) ? 0 : addr_q+1; rem<=rem-1.
  - When the fetch has rem==1, next state is DRAIN.
- Output handshake: out_valid stays high and out_coef/out_last are stable while out_ready=0.
  - If out_ready=1 and no fetch occurs, out_valid<=0.
- DRAIN: on out_valid && out_ready && out_last, go to IDLE, out_valid<=0 and done<=1 for the next cycle.
  - A new request is acknowledged no earlier than the cycle done is high.
- Latency: ack in cycle T, first out_valid in T+2. With out_ready held at 1, throughput is 1 beat/cycle and an N-beat burst finishes its last beat in T+N+1.
- Wrap: len may exceed DEPTH (up to 255); addresses cycle modulo DEPTH.
- busy = (state != IDLE).

Test Plan:
1. Single burst: req0, base0=0, len0=4, out_ready=1.
   - ack0 at T; out_coef=0x001e,0x001f,0x0024,0x0022 in T+2..T+5; out_last in T+5; out_src=0; done in T+6.
2. Wrap-around: req1, base1=78, len1=4.
   - Addresses 78,79,0,1; out_coef=0x001d,0x001b,0x001e,0x001f; out_src=1.
3. Backpressure: base=8, len=3, out_ready low for 3 cycles after the first out_valid.
   - 0x0027 held stable; then 0x0022,0x001c delivered in order; no beat lost or duplicated.
4. Simultaneous requests: req0 and req1 both high from reset, each len=2.
   - Grant order 0,1.
   - Re-raising both requests after that pair completes gives order 0,1 again, since rr_ptr toggles on each grant.
   - Streams never interleave.
5. Degenerate descriptors:
   - base0=80, len0=5: ack0, err+done in T+1, no out_valid.
   - base0=3, len0=0: ack0, done only.
6. Reset mid-burst: len=10, rst asserted after the 4th beat.
   - Next cycle all outputs are 0, state IDLE, no done.
   - A fresh request afterwards streams correctly from its base.
